sum_accumulator: RTL and testbench

Downstream consumer of the registered 32-bit adder stage. It collects a programmed number of consecutive sum results into a wide accumulator and flags overflow. It presents the total to the next stage over a valid/ready handshake. One job runs at a time: start, accept `len` beats, hold the result until it is taken, return to idle.

---
 rtl/sum_accumulator.sv | 82 ++++++++
 tb/tb_sum_accumulator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates a programmed number of sum beats and hands the total downstream
module sum_accumulator #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              overflow,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum;

    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};

    // next state: clear overrides everything, then per-state job sequencing
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            rem_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len != '0) ? ACC : DONE;
                end
                ACC: if (in_valid) begin
                    acc_d   = sum[ACC_W-1:0];
                    ovf_d   = ovf_q | sum[ACC_W];
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == LEN_W'(1)) ? DONE : ACC;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: randomized self-checking bench for sum_accumulator (ACC_W=33)
module tb_sum_accumulator;
    logic        clk = 0, reset = 0, clear = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [7:0]  len = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, out_valid, overflow, busy;
    logic [32:0] out_data;
    int          total = 0, bad = 0;
    logic [31:0] bq[$];

    sum_accumulator #(.DATA_W(32), .ACC_W(33), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // true arithmetic total of the first nb queued beats
    function automatic logic [63:0] model_total(input int nb);
        logic [63:0] t = 0;
        for (int i = 0; i < nb; i++) t += 64'(bq[i]);
        return t;
    endfunction

    task automatic feed(input logic [7:0] n, input int nb, input int gap);
        start = 1; len = n; step(); start = 0;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(gap, 0)) step();
            in_valid = 1; in_data = bq[i]; step(); in_valid = 0;
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if ({in_ready, out_valid, overflow, busy} !== 4'b0 || out_data !== 0) begin
            bad++; $display("FAIL reset_async got=%b/%0h exp=0", {in_ready, out_valid, overflow, busy}, out_data); end
        step(); step();
        total++; if ({in_ready, out_valid, overflow, busy} !== 4'b0 || out_data !== 0) begin
            bad++; $display("FAIL reset_held got=%b/%0h exp=0", {in_ready, out_valid, overflow, busy}, out_data); end
        reset = 1; step();
        total++; if (busy !== 0) begin bad++; $display("FAIL reset_release busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        bq = '{10, 20, 30};
        start = 1; len = 3; step(); start = 0;
        total++; if (in_ready !== 1 || busy !== 1) begin
            bad++; $display("FAIL basic_inready got=%b%b exp=11", in_ready, busy); end
        for (int i = 0; i < 3; i++) begin in_valid = 1; in_data = bq[i]; step(); end
        in_valid = 0;
        total++; if (out_valid !== 1 || in_ready !== 0) begin
            bad++; $display("FAIL basic_done got=%b%b exp=10", out_valid, in_ready); end
        total++; if (out_data !== model_total(3) || overflow !== 0) begin
            bad++; $display("FAIL basic_data got=%0d/%b exp=%0d/0", out_data, overflow, model_total(3)); end
        out_ready = 1; step(); out_ready = 0;
        total++; if (busy !== 0 || out_valid !== 0 || out_data !== 60) begin
            bad++; $display("FAIL basic_idle got=%b%b/%0d exp=00/60", busy, out_valid, out_data); end
    endtask

    task automatic test_backpressure();
        bq = '{1, 2, 3, 4};
        feed(4, 4, 2);
        for (int i = 0; i < 5; i++) begin
            start = i[0]; len = 8'd7;
            total++; if (out_valid !== 1 || in_ready !== 0 || out_data !== 10 || overflow !== 0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b%b/%0d exp=10/10", i, out_valid, in_ready, out_data); end
            step();
        end
        start = 0; out_ready = 1; step(); out_ready = 0;
        total++; if (busy !== 0 || out_data !== 10) begin
            bad++; $display("FAIL bp_release got=%b/%0d exp=0/10", busy, out_data); end
    endtask

    task automatic test_overflow();
        logic [63:0] t;
        bq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        feed(3, 3, 1);
        t = model_total(3);
        total++; if (out_data !== t[32:0] || overflow !== (t >= 64'h2_0000_0000)) begin
            bad++; $display("FAIL ovf_wrap got=%0h/%b exp=%0h/1", out_data, overflow, t[32:0]); end
        out_ready = 1; step(); out_ready = 0;
        total++; if (overflow !== 1) begin bad++; $display("FAIL ovf_retained got=%b exp=1", overflow); end
        bq = '{5};
        feed(1, 1, 0);
        total++; if (out_data !== 5 || overflow !== 0) begin
            bad++; $display("FAIL ovf_next got=%0h/%b exp=5/0", out_data, overflow); end
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_zero_len();
        start = 1; len = 0; step(); start = 0;
        total++; if (out_valid !== 1 || out_data !== 0 || in_ready !== 0 || overflow !== 0) begin
            bad++; $display("FAIL zero_done got=%b%b/%0h exp=10/0", out_valid, in_ready, out_data); end
        out_ready = 1; step(); out_ready = 0;
        total++; if (busy !== 0) begin bad++; $display("FAIL zero_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_abort();
        bq = '{100, 200};
        feed(5, 2, 0);
        clear = 1; start = 1; len = 3; step(); clear = 0; start = 0;
        total++; if (in_ready !== 0 || busy !== 0 || out_data !== 0) begin
            bad++; $display("FAIL abort_idle got=%b%b/%0d exp=00/0", in_ready, busy, out_data); end
        in_valid = 1; in_data = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (out_valid !== 0) begin bad++; $display("FAIL abort_novalid got=%b exp=0", out_valid); end
        end
        in_valid = 0;
        bq = '{7, 8};
        feed(2, 2, 1);
        total++; if (out_data !== 15) begin bad++; $display("FAIL abort_next got=%0d exp=15", out_data); end
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_async_reset();
        bq = '{50, 60};
        feed(5, 2, 0);
        #2 reset = 0;
        #1;
        total++; if ({in_ready, out_valid, overflow, busy} !== 4'b0 || out_data !== 0) begin
            bad++; $display("FAIL areset_mid got=%b/%0h exp=0", {in_ready, out_valid, overflow, busy}, out_data); end
        #2 reset = 1;
        step();
        bq = '{9};
        feed(1, 1, 0);
        total++; if (out_valid !== 1 || out_data !== 9) begin
            bad++; $display("FAIL areset_next got=%b/%0d exp=1/9", out_valid, out_data); end
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_random();
        for (int j = 0; j < 30; j++) begin
            int n;
            logic [63:0] t;
            int cnt;
            n = $urandom_range(6, 0);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 | $urandom_range(15, 0) : $urandom);
            feed(8'(n), n, 2);
            t = model_total(n);
            cnt = 0;
            while (out_valid !== 1 && cnt < 20) begin step(); cnt++; end
            total++; if (out_valid !== 1) begin bad++; $display("FAIL rand_timeout job=%0d", j); end
            repeat ($urandom_range(3, 0)) step();
            total++; if (out_data !== t[32:0] || overflow !== (t >= 64'h2_0000_0000)) begin
                bad++; $display("FAIL rand_data job=%0d got=%0h/%b exp=%0h/%b", j, out_data, overflow, t[32:0], t >= 64'h2_0000_0000); end
            out_ready = 1; step(); out_ready = 0;
            total++; if (busy !== 0) begin bad++; $display("FAIL rand_idle job=%0d busy=%b exp=0", j, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_zero_len();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
